fpdiv_generic: RTL and testbench

Parametrised IEEE-754 floating-point divider: the next-generation replacement for the fixed single-precision divider in the FPU datapath. It keeps the same stb/ack operand and result handshake. It adds:
- configurable exponent/fraction widths
- four run-time rounding modes
- IEEE exception flags
- a one-cycle-per-bit divide loop

---
 rtl/fpdiv_pkg.sv | 26 ++
 rtl/fpdiv_round.sv | 47 ++++
 rtl/fpdiv_generic.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_fpdiv_generic.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/fpdiv_pkg.sv
// rtl/fpdiv_pkg.sv - shared state/rounding types, flag indices and bias helper for fpdiv_generic
package fpdiv_pkg;

  typedef enum logic [3:0] {
    GET_A, GET_B, UNPACK, SPECIAL, NORM_A, NORM_B, DIV_INIT,
    DIV, ALIGN, DENORM, ROUND, PACK, PUT_Z
  } state_t;

  typedef enum logic [1:0] {
    RNE = 2'b00,
    RTZ = 2'b01,
    RUP = 2'b10,
    RDN = 2'b11
  } rnd_t;

  localparam int FLAG_INVALID   = 4;
  localparam int FLAG_DIVZERO   = 3;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_INEXACT   = 0;

  function automatic int bias_of(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

endpackage

// File: rtl/fpdiv_round.sv
// rtl/fpdiv_round.sv - rounding increment, overflow result choice and inexact/underflow flags
module fpdiv_round
  import fpdiv_pkg::*;
(
  input  logic [1:0] rnd_mode,
  input  logic       sign,
  input  logic       lsb,
  input  logic       guard,
  input  logic       round_bit,
  input  logic       sticky,
  input  logic       tiny,
  output logic       inc,
  output logic       inexact,
  output logic       ovf_inf,
  output logic       underflow
);

  always_comb begin
    inexact   = guard | round_bit | sticky;
    inc       = 1'b0;
    ovf_inf   = 1'b0;
    case (rnd_t'(rnd_mode))
      RNE: begin
        inc     = guard & (round_bit | sticky | lsb);
        ovf_inf = 1'b1;
      end
      RTZ: begin
        inc     = 1'b0;
        ovf_inf = 1'b0;
      end
      RUP: begin
        inc     = inexact & ~sign;
        ovf_inf = ~sign;
      end
      RDN: begin
        inc     = inexact & sign;
        ovf_inf = sign;
      end
      default: begin
        inc     = 1'b0;
        ovf_inf = 1'b0;
      end
    endcase
    underflow = tiny & inexact;
  end

endmodule

// File: rtl/fpdiv_generic.sv
// rtl/fpdiv_generic.sv - parametrised IEEE-754 divider, stb/ack handshake, one quotient bit per cycle
// Gradual underflow (subnormal inputs and results) is enabled by defining FPDIV_DENORM_EN.
module fpdiv_generic
  import fpdiv_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [EXP_W+MAN_W:0] input_a,
  input  logic                 input_a_stb,
  output logic                 input_a_ack,
  input  logic [EXP_W+MAN_W:0] input_b,
  input  logic                 input_b_stb,
  output logic                 input_b_ack,
  input  logic [1:0]           rnd_mode,
  output logic [EXP_W+MAN_W:0] output_z,
  output logic                 output_z_stb,
  input  logic                 output_z_ack,
  output logic [4:0]           output_flags
);

  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int N    = MAN_W + 4;
  localparam int EW   = EXP_W + 2;
  localparam int CW   = $clog2(N);
  localparam int BIAS = bias_of(EXP_W);
  localparam logic signed [EW-1:0] E_MIN    = EW'(1 - BIAS);
  localparam logic signed [EW-1:0] E_MAX    = EW'(BIAS);
  localparam logic [CW-1:0]        CNT_LAST = CW'(N - 1);
  localparam logic [4:0] F_INV = 5'd1 << FLAG_INVALID;
  localparam logic [4:0] F_DZ  = 5'd1 << FLAG_DIVZERO;
  localparam logic [4:0] F_OVF = 5'd1 << FLAG_OVERFLOW;
  localparam logic [4:0] F_UNF = 5'd1 << FLAG_UNDERFLOW;
  localparam logic [4:0] F_INX = 5'd1 << FLAG_INEXACT;
  localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};
  localparam logic [EXP_W-1:0] EXP_MAXF = {{(EXP_W-1){1'b1}}, 1'b0};
  localparam logic [W-1:0] NAN_Z = {1'b1, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

  state_t state, state_nxt;

  logic [W-1:0]          a_raw, b_raw;
  logic [1:0]            mode_q;
  logic                  a_s, b_s, z_s;
  logic signed [EW-1:0]  a_e, b_e, z_e;
  logic [MAN_W:0]        a_m, b_m, z_m;
  logic                  a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
  logic [MAN_W+1:0]      rem;
  logic [N-1:0]          q;
  logic [CW-1:0]         count;
  logic                  g_bit, r_bit, s_bit, flush;

  logic [EXP_W-1:0]      ua_exp, ub_exp;
  logic [MAN_W-1:0]      ua_frac, ub_frac;
  logic                  ua_ez, ub_ez, ua_eo, ub_eo, ua_fz, ub_fz, ua_zero, ub_zero;
  logic signed [EW-1:0]  ua_e, ub_e;

  assign ua_exp  = a_raw[W-2:MAN_W];
  assign ub_exp  = b_raw[W-2:MAN_W];
  assign ua_frac = a_raw[MAN_W-1:0];
  assign ub_frac = b_raw[MAN_W-1:0];
  assign ua_ez   = (ua_exp == '0);
  assign ub_ez   = (ub_exp == '0);
  assign ua_eo   = &ua_exp;
  assign ub_eo   = &ub_exp;
  assign ua_fz   = (ua_frac == '0);
  assign ub_fz   = (ub_frac == '0);
  assign ua_e    = ua_ez ? E_MIN : $signed({2'b00, ua_exp}) - E_MAX;
  assign ub_e    = ub_ez ? E_MIN : $signed({2'b00, ub_exp}) - E_MAX;

`ifdef FPDIV_DENORM_EN
  assign ua_zero = ua_ez & ua_fz;
  assign ub_zero = ub_ez & ub_fz;
`else
  assign ua_zero = ua_ez;
  assign ub_zero = ub_ez;
`endif

  logic                  is_special, is_invalid;
  logic                  div_ge;
  logic [MAN_W:0]        rem_sub;
  logic [N-1:0]          q_al;
  logic [MAN_W+1:0]      rnd_sum;
  logic [EXP_W-1:0]      z_bexp;
  logic                  rnd_inc, rnd_inexact, rnd_ovf_inf, rnd_underflow;

  assign is_invalid = a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf);
  assign is_special = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;
  // rem never exceeds 2*b_m, so the low MAN_W+1 bits of the difference are exact when div_ge
  assign div_ge     = (rem >= {1'b0, b_m});
  assign rem_sub    = rem[MAN_W:0] - b_m;
  assign q_al       = q[N-1] ? q : {q[N-2:0], 1'b0};
  assign rnd_sum    = {1'b0, z_m} + {{(MAN_W+1){1'b0}}, rnd_inc};
  assign z_bexp     = z_e[EXP_W-1:0] + EXP_W'(BIAS);

  fpdiv_round u_round (
    .rnd_mode  (mode_q),
    .sign      (z_s),
    .lsb       (z_m[0]),
    .guard     (g_bit),
    .round_bit (r_bit),
    .sticky    (s_bit),
    .tiny      (~z_m[MAN_W]),
    .inc       (rnd_inc),
    .inexact   (rnd_inexact),
    .ovf_inf   (rnd_ovf_inf),
    .underflow (rnd_underflow)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      GET_A:    if (input_a_ack && input_a_stb) state_nxt = GET_B;
      GET_B:    if (input_b_ack && input_b_stb) state_nxt = UNPACK;
      UNPACK:   state_nxt = SPECIAL;
      SPECIAL:  state_nxt = is_special ? PUT_Z : NORM_A;
`ifdef FPDIV_DENORM_EN
      NORM_A:   if (a_m[MAN_W]) state_nxt = NORM_B;
      NORM_B:   if (b_m[MAN_W]) state_nxt = DIV_INIT;
      DENORM:   if (z_e >= E_MIN) state_nxt = ROUND;
`else
      NORM_A:   state_nxt = NORM_B;
      NORM_B:   state_nxt = DIV_INIT;
      DENORM:   state_nxt = ROUND;
`endif
      DIV_INIT: state_nxt = DIV;
      DIV:      if (count == CNT_LAST) state_nxt = ALIGN;
      ALIGN:    state_nxt = DENORM;
      ROUND:    state_nxt = PACK;
      PACK:     state_nxt = PUT_Z;
      PUT_Z:    if (output_z_stb && output_z_ack) state_nxt = GET_A;
      default:  state_nxt = GET_A;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= GET_A;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      input_a_ack  <= 1'b0;
      input_b_ack  <= 1'b0;
      output_z_stb <= 1'b0;
      output_z     <= '0;
      output_flags <= '0;
      a_raw <= '0;  b_raw <= '0;  mode_q <= '0;
      a_s <= 1'b0;  b_s <= 1'b0;  z_s <= 1'b0;
      a_e <= '0;    b_e <= '0;    z_e <= '0;
      a_m <= '0;    b_m <= '0;    z_m <= '0;
      a_zero <= 1'b0; a_inf <= 1'b0; a_nan <= 1'b0;
      b_zero <= 1'b0; b_inf <= 1'b0; b_nan <= 1'b0;
      rem <= '0;  q <= '0;  count <= '0;
      g_bit <= 1'b0; r_bit <= 1'b0; s_bit <= 1'b0; flush <= 1'b0;
    end else begin
      case (state)
        GET_A: begin
          if (input_a_ack && input_a_stb) begin
            a_raw       <= input_a;
            input_a_ack <= 1'b0;
          end else begin
            input_a_ack <= 1'b1;
          end
        end
        GET_B: begin
          if (input_b_ack && input_b_stb) begin
            b_raw       <= input_b;
            mode_q      <= rnd_mode;
            input_b_ack <= 1'b0;
          end else begin
            input_b_ack <= 1'b1;
          end
        end
        UNPACK: begin
          a_s    <= a_raw[W-1];
          b_s    <= b_raw[W-1];
          a_e    <= ua_e;
          b_e    <= ub_e;
          a_m    <= {~ua_ez, ua_frac};
          b_m    <= {~ub_ez, ub_frac};
          a_zero <= ua_zero;
          b_zero <= ub_zero;
          a_inf  <= ua_eo & ua_fz;
          b_inf  <= ub_eo & ub_fz;
          a_nan  <= ua_eo & ~ua_fz;
          b_nan  <= ub_eo & ~ub_fz;
        end
        SPECIAL: begin
          if (is_invalid) begin
            output_z     <= NAN_Z;
            output_flags <= F_INV;
          end else if (a_inf) begin
            output_z     <= {a_s ^ b_s, EXP_ONES, {MAN_W{1'b0}}};
            output_flags <= '0;
          end else if (b_zero) begin
            output_z     <= {a_s ^ b_s, EXP_ONES, {MAN_W{1'b0}}};
            output_flags <= F_DZ;
          end else begin
            output_z     <= {a_s ^ b_s, {(W-1){1'b0}}};
            output_flags <= '0;
          end
          if (is_special) output_z_stb <= 1'b1;
        end
`ifdef FPDIV_DENORM_EN
        NORM_A: begin
          if (!a_m[MAN_W]) begin
            a_m <= {a_m[MAN_W-1:0], 1'b0};
            a_e <= a_e - 1'b1;
          end
        end
        NORM_B: begin
          if (!b_m[MAN_W]) begin
            b_m <= {b_m[MAN_W-1:0], 1'b0};
            b_e <= b_e - 1'b1;
          end
        end
`endif
        DIV_INIT: begin
          rem   <= {1'b0, a_m};
          z_e   <= a_e - b_e;
          z_s   <= a_s ^ b_s;
          count <= '0;
          q     <= '0;
          flush <= 1'b0;
        end
        DIV: begin
          q     <= {q[N-2:0], div_ge};
          rem   <= div_ge ? {rem_sub, 1'b0} : {rem[MAN_W:0], 1'b0};
          count <= count + 1'b1;
        end
        ALIGN: begin
          z_m   <= q_al[N-1:N-1-MAN_W];
          g_bit <= q_al[N-2-MAN_W];
          r_bit <= q_al[N-3-MAN_W];
          s_bit <= (|q_al[N-4-MAN_W:0]) | (|rem);
          if (!q[N-1]) z_e <= z_e - 1'b1;
        end
        DENORM: begin
`ifdef FPDIV_DENORM_EN
          if (z_e < E_MIN) begin
            z_m   <= {1'b0, z_m[MAN_W:1]};
            g_bit <= z_m[0];
            r_bit <= g_bit;
            s_bit <= s_bit | r_bit;
            z_e   <= z_e + 1'b1;
          end
`else
          flush <= (z_e < E_MIN);
`endif
        end
        ROUND: begin
          if (rnd_sum[MAN_W+1]) begin
            z_m <= rnd_sum[MAN_W+1:1];
            z_e <= z_e + 1'b1;
          end else begin
            z_m <= rnd_sum[MAN_W:0];
          end
        end
        PACK: begin
          output_z_stb <= 1'b1;
          if (flush) begin
            output_z     <= {z_s, {(W-1){1'b0}}};
            output_flags <= F_UNF | F_INX;
          end else if (z_e > E_MAX) begin
            output_z     <= rnd_ovf_inf ? {z_s, EXP_ONES, {MAN_W{1'b0}}}
                                        : {z_s, EXP_MAXF, {MAN_W{1'b1}}};
            output_flags <= F_OVF | F_INX;
          end else begin
            // a tiny result keeps hidden bit 0 and packs with exponent field 0
            output_z     <= {z_s, (z_m[MAN_W] ? z_bexp : {EXP_W{1'b0}}), z_m[MAN_W-1:0]};
            output_flags <= (rnd_underflow ? F_UNF : 5'd0) | (rnd_inexact ? F_INX : 5'd0);
          end
        end
        PUT_Z: begin
          if (output_z_stb && output_z_ack) output_z_stb <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpdiv_generic.sv
// tb/tb_fpdiv_generic.sv - scoreboard bench for fpdiv_generic with directed divide vectors
module tb_fpdiv_generic;
  import fpdiv_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] input_a, input_b, output_z;
  logic        input_a_stb, input_a_ack, input_b_stb, input_b_ack;
  logic        output_z_stb, output_z_ack;
  logic [1:0]  rnd_mode;
  logic [4:0]  output_flags;

  logic [15:0] h_a, h_b, h_z;
  logic        h_a_stb, h_a_ack, h_b_stb, h_b_ack, h_z_stb, h_z_ack;
  logic [1:0]  h_mode;
  logic [4:0]  h_flags;

  fpdiv_generic dut (
    .clk(clk), .rst_n(rst_n),
    .input_a(input_a), .input_a_stb(input_a_stb), .input_a_ack(input_a_ack),
    .input_b(input_b), .input_b_stb(input_b_stb), .input_b_ack(input_b_ack),
    .rnd_mode(rnd_mode),
    .output_z(output_z), .output_z_stb(output_z_stb), .output_z_ack(output_z_ack),
    .output_flags(output_flags)
  );

  fpdiv_generic #(.EXP_W(5), .MAN_W(10)) dut_h (
    .clk(clk), .rst_n(rst_n),
    .input_a(h_a), .input_a_stb(h_a_stb), .input_a_ack(h_a_ack),
    .input_b(h_b), .input_b_stb(h_b_stb), .input_b_ack(h_b_ack),
    .rnd_mode(h_mode),
    .output_z(h_z), .output_z_stb(h_z_stb), .output_z_ack(h_z_ack),
    .output_flags(h_flags)
  );

  typedef struct {
    logic [31:0] z;
    logic [4:0]  f;
    int          lat;
    int          hold;
    int          t_acc;
    int          id;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int pushed = 0;
  int popped = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%h required=0x%h", nm, act, req);
    end
  endtask

  task automatic issue(input int id, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] m, input logic [31:0] ez, input logic [4:0] ef,
                       input int lat, input int hold, input bit push);
    int n;
    exp_t e;
    input_a = a;
    input_a_stb = 1'b1;
    n = 0;
    while (input_a_ack !== 1'b1 && n < 500) begin @(negedge clk); n++; end
    if (input_a_ack !== 1'b1) begin
      checks++; failures++;
      $display("FAIL a_ack_timeout[%0d] actual=0 required=1", id);
      input_a_stb = 1'b0;
      return;
    end
    @(negedge clk);
    input_a_stb = 1'b0;
    input_b = b;
    rnd_mode = m;
    input_b_stb = 1'b1;
    n = 0;
    while (input_b_ack !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (input_b_ack !== 1'b1) begin
      checks++; failures++;
      $display("FAIL b_ack_timeout[%0d] actual=0 required=1", id);
      input_b_stb = 1'b0;
      return;
    end
    @(negedge clk);
    input_b_stb = 1'b0;
    if (push) begin
      e.z = ez; e.f = ef; e.lat = lat; e.hold = hold; e.t_acc = cyc; e.id = id;
      sb.push_back(e);
      pushed++;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (popped < pushed && n < 3000) begin @(negedge clk); n++; end
    if (popped < pushed) begin
      checks++; failures++;
      $display("FAIL drain_timeout actual=%0d required=%0d", popped, pushed);
    end
  endtask

  initial begin : monitor
    exp_t e;
    logic [31:0] hz;
    logic [4:0]  hf;
    logic        ok;
    output_z_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (output_z_stb === 1'b1) begin
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_result actual=0x%h required=none", output_z);
        end else begin
          e = sb.pop_front();
          check($sformatf("z[%0d]", e.id), output_z, e.z);
          check($sformatf("flags[%0d]", e.id), 32'(output_flags), 32'(e.f));
          if (e.lat > 0) check($sformatf("latency[%0d]", e.id), 32'(cyc - e.t_acc), 32'(e.lat));
          if (e.hold > 0) begin
            hz = output_z; hf = output_flags; ok = 1'b1;
            repeat (e.hold) begin
              @(negedge clk);
              if (output_z !== hz || output_flags !== hf || output_z_stb !== 1'b1) ok = 1'b0;
            end
            check($sformatf("hold[%0d]", e.id), 32'(ok), 32'd1);
          end
          popped++;
        end
        output_z_ack = 1'b1;
        @(negedge clk);
        output_z_ack = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #200000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : main
    int n;
    int t0;
    input_a = '0; input_b = '0; input_a_stb = 1'b0; input_b_stb = 1'b0; rnd_mode = 2'b00;
    h_a = '0; h_b = '0; h_a_stb = 1'b0; h_b_stb = 1'b0; h_mode = 2'b00; h_z_ack = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_z", output_z, 32'h0);
    check("rst_flags", 32'(output_flags), 32'h0);
    check("rst_stb", 32'(output_z_stb), 32'h0);
    check("rst_a_ack", 32'(input_a_ack), 32'h0);
    check("rst_b_ack", 32'(input_b_ack), 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("a_ack_rise", 32'(input_a_ack), 32'h1);

    issue(1,  32'h40C00000, 32'h40000000, 2'b00, 32'h40400000, 5'h00, 36, 0, 1'b1);
    issue(2,  32'h3F800000, 32'h40400000, 2'b00, 32'h3EAAAAAB, 5'h01, 36, 0, 1'b1);
    issue(3,  32'h3F800000, 32'h40400000, 2'b01, 32'h3EAAAAAA, 5'h01, 36, 0, 1'b1);
    issue(4,  32'h3F800000, 32'h40400000, 2'b10, 32'h3EAAAAAB, 5'h01, 36, 0, 1'b1);
    issue(5,  32'h3F800000, 32'h40400000, 2'b11, 32'h3EAAAAAA, 5'h01, 36, 0, 1'b1);
    issue(6,  32'hC0C00000, 32'h40000000, 2'b00, 32'hC0400000, 5'h00, 36, 0, 1'b1);
    issue(7,  32'h3F800000, 32'h00000000, 2'b00, 32'h7F800000, 5'h08, 2, 0, 1'b1);
    issue(8,  32'h7F800000, 32'h3F800000, 2'b00, 32'h7F800000, 5'h00, 2, 0, 1'b1);
    issue(9,  32'h3F800000, 32'h7F800000, 2'b00, 32'h00000000, 5'h00, 2, 0, 1'b1);
    issue(10, 32'h7FC00000, 32'h3F800000, 2'b00, 32'hFFC00000, 5'h10, 2, 0, 1'b1);
    issue(11, 32'h40C00000, 32'h40000000, 2'b00, 32'h40400000, 5'h00, 36, 10, 1'b1);
    issue(12, 32'h7F7FFFFF, 32'h3F000000, 2'b00, 32'h7F800000, 5'h05, 36, 0, 1'b1);
    issue(13, 32'h7F7FFFFF, 32'h3F000000, 2'b01, 32'h7F7FFFFF, 5'h05, 36, 0, 1'b1);
    issue(14, 32'hFF7FFFFF, 32'h3F000000, 2'b11, 32'hFF800000, 5'h05, 36, 0, 1'b1);
`ifdef FPDIV_DENORM_EN
    issue(15, 32'h00800000, 32'h40000000, 2'b00, 32'h00400000, 5'h00, 37, 0, 1'b1);
`else
    issue(15, 32'h00800000, 32'h40000000, 2'b00, 32'h00000000, 5'h03, 36, 0, 1'b1);
`endif
    issue(16, 32'h00000000, 32'h00000000, 2'b00, 32'hFFC00000, 5'h10, 2, 0, 1'b1);
    drain();

    issue(100, 32'h3F800000, 32'h40400000, 2'b00, 32'h0, 5'h0, 0, 0, 1'b0);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_z", output_z, 32'h0);
    check("mid_rst_flags", 32'(output_flags), 32'h0);
    check("mid_rst_stb", 32'(output_z_stb), 32'h0);
    check("mid_rst_acks", {30'd0, input_a_ack, input_b_ack}, 32'h0);
    check("mid_rst_state", 32'(dut.state == GET_A), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    issue(17, 32'h3F800000, 32'h40400000, 2'b00, 32'h3EAAAAAB, 5'h01, 36, 0, 1'b1);
    drain();

    h_a = 16'h4200;
    h_a_stb = 1'b1;
    n = 0;
    while (h_a_ack !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    h_a_stb = 1'b0;
    h_b = 16'h4000;
    h_b_stb = 1'b1;
    n = 0;
    while (h_b_ack !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    h_b_stb = 1'b0;
    t0 = cyc;
    n = 0;
    while (h_z_stb !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    check("half_z", 32'(h_z), 32'h3E00);
    check("half_flags", 32'(h_flags), 32'h0);
    check("half_latency", 32'(cyc - t0), 32'd23);
    h_z_ack = 1'b1;
    @(negedge clk);
    h_z_ack = 1'b0;
    check("half_stb_drop", 32'(h_z_stb), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
